// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard for decode/issue and writeback.
// Latency: reads are combinational (0 cycles); writes and reservations take effect on the next rising edge.
// Backpressure: issue_ready drops while the destination is reserved; writes are always accepted.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   wen, waddr, wdata          writeback port; writes to index 0 are ignored
//   raddr, rdata, rbusy        NR_READ packed read ports (index, data, pending-producer flag)
//   issue_valid, issue_rd      destination reservation request from decode
//   issue_ready                reservation can be accepted this cycle
//   wr_count                   free-running count of committed nonzero-index writes
module regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rbusy,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,
    output logic                          issue_ready,
    output logic [31:0]                   wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [31:0]           wr_cnt;

    logic write_act;
    logic fwd_act;
    logic issue_acc;

    assign write_act = wen && (waddr != '0);
    // Forwarding is suppressed while reset is held so outputs read as cleared state.
    assign fwd_act   = (BYPASS != 0) && rst_n && write_act;
    assign issue_acc = issue_valid && issue_ready && (issue_rd != '0);
    assign wr_count  = wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
            busy   <= '0;
            wr_cnt <= '0;
        end else begin
            if (write_act) begin
                rf[waddr]   <= wdata;
                busy[waddr] <= 1'b0;
                wr_cnt      <= wr_cnt + 32'd1;
            end
            // Placed after the write so a same-index reservation overrides the clear.
            if (issue_acc) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < NR_READ; p++) begin
            if (raddr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy[p]                          = 1'b0;
            end else if (fwd_act && (waddr == raddr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
                rbusy[p]                          = 1'b0;
            end else begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
                rbusy[p]                          = busy[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    always_comb begin
        issue_ready = 1'b1;
        if ((issue_rd != '0) && !(fwd_act && (waddr == issue_rd))) begin
            issue_ready = !busy[issue_rd];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench driving a forwarding instance and a non-forwarding instance from shared stimulus.
// Inputs change 1 time unit after the rising edge and outputs are checked 1 unit later.
// Expected values are hand-derived constants for each step.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic [63:0] b_rdata, n_rdata;
    logic [1:0]  b_rbusy, n_rbusy;
    logic        b_ready, n_ready;
    logic [31:0] b_cnt, n_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(b_ready),
        .wr_count(b_cnt)
    );

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(n_rdata), .rbusy(n_rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(n_ready),
        .wr_count(n_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen         = 1'b0;
        waddr       = '0;
        wdata       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        raddr = {5'd0, 5'd5};

        // Reset state
        #2;
        chk("rst_b_rdata0", b_rdata[31:0], 32'h0);
        chk("rst_b_rbusy",  {30'd0, b_rbusy}, 32'h0);
        chk("rst_b_ready",  {31'd0, b_ready}, 32'h1);
        chk("rst_b_cnt",    b_cnt, 32'h0);
        chk("rst_n_ready",  {31'd0, n_ready}, 32'h1);
        #10 rst_n = 1'b1;

        // Write x5 = DEADBEEF; forwarded only in the bypass instance
        tick();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        #1;
        chk("wr5_b_fwd", b_rdata[31:0], 32'hDEADBEEF);
        chk("wr5_n_old", n_rdata[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("wr5_b_after", b_rdata[31:0], 32'hDEADBEEF);
        chk("wr5_n_after", n_rdata[31:0], 32'hDEADBEEF);
        chk("wr5_cnt", b_cnt, 32'd1);

        // Reserve x5, then reset mid-cycle without a clock edge
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        idle();
        issue_rd = 5'd5;
        #1;
        chk("rsv5_b_busy",  {31'd0, b_rbusy[0]}, 32'h1);
        chk("rsv5_b_ready", {31'd0, b_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_b_rdata0", b_rdata[31:0], 32'h0);
        chk("mrst_n_rdata0", n_rdata[31:0], 32'h0);
        chk("mrst_b_rbusy",  {31'd0, b_rbusy[0]}, 32'h0);
        chk("mrst_b_ready",  {31'd0, b_ready}, 32'h1);
        chk("mrst_b_cnt",    b_cnt, 32'h0);
        #1 rst_n = 1'b1;

        // Zero register: write and issue to x0 have no effect
        tick();
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        raddr = {5'd0, 5'd0};
        #1;
        chk("x0_b_rdata0", b_rdata[31:0], 32'h0);
        chk("x0_b_rdata1", b_rdata[63:32], 32'h0);
        chk("x0_b_rbusy",  {30'd0, b_rbusy}, 32'h0);
        chk("x0_b_ready",  {31'd0, b_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("x0_b_after", b_rdata[31:0], 32'h0);
        chk("x0_b_cnt",   b_cnt, 32'h0);
        chk("x0_n_cnt",   n_cnt, 32'h0);
        chk("x0_b_ready2", {31'd0, b_ready}, 32'h1);

        // Load x7 = 11111111 and reserve it in the same cycle: busy wins
        wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        raddr = {5'd7, 5'd7};
        wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678; issue_rd = 5'd7;
        #1;
        chk("byp_b_rdata0", b_rdata[31:0], 32'h12345678);
        chk("byp_b_rdata1", b_rdata[63:32], 32'h12345678);
        chk("byp_b_rbusy",  {30'd0, b_rbusy}, 32'h0);
        chk("byp_b_ready",  {31'd0, b_ready}, 32'h1);
        chk("byp_n_rdata0", n_rdata[31:0], 32'h11111111);
        chk("byp_n_rdata1", n_rdata[63:32], 32'h11111111);
        chk("byp_n_rbusy",  {30'd0, n_rbusy}, 32'h3);
        chk("byp_n_ready",  {31'd0, n_ready}, 32'h0);
        tick();
        idle();
        issue_rd = 5'd7;
        #1;
        chk("byp_n_rdata_nx", n_rdata[31:0], 32'h12345678);
        chk("byp_n_rbusy_nx", {30'd0, n_rbusy}, 32'h0);
        chk("byp_n_ready_nx", {31'd0, n_ready}, 32'h1);
        chk("byp_b_cnt",      b_cnt, 32'd2);

        // Scoreboard on x3
        raddr = {5'd7, 5'd3};
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("sb3_b_rbusy", {30'd0, b_rbusy}, 32'h1);
        chk("sb3_b_ready", {31'd0, b_ready}, 32'h0);
        chk("sb3_n_ready", {31'd0, n_ready}, 32'h0);
        // Write x3 and re-issue x3 together; only the forwarding instance can accept
        wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; issue_valid = 1'b1;
        tick();
        idle();
        issue_rd = 5'd3;
        #1;
        chk("sb3_b_rdata", b_rdata[31:0], 32'hCAFEF00D);
        chk("sb3_b_busy2", {30'd0, b_rbusy}, 32'h1);
        chk("sb3_b_rdy2",  {31'd0, b_ready}, 32'h0);
        chk("sb3_n_rdata", n_rdata[31:0], 32'hCAFEF00D);
        chk("sb3_n_busy2", {30'd0, n_rbusy}, 32'h0);
        chk("sb3_b_p1",    b_rdata[63:32], 32'h12345678);
        chk("sb3_cnt",     b_cnt, 32'd3);

        // Write to a register that was never reserved
        raddr = {5'd0, 5'd9};
        wen = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        tick();
        idle();
        #1;
        chk("nb9_rdata", b_rdata[31:0], 32'hA5A5A5A5);
        chk("nb9_rbusy", {30'd0, b_rbusy}, 32'h0);
        chk("nb9_cnt",   b_cnt, 32'd4);

        // Counter wrap from a preloaded all-ones value
        force u_byp.wr_cnt = 32'hFFFFFFFF;
        #1;
        release u_byp.wr_cnt;
        #1;
        chk("wrap_pre", b_cnt, 32'hFFFFFFFF);
        wen = 1'b1; waddr = 5'd1; wdata = 32'h1;
        tick();
        idle();
        #1;
        chk("wrap_cnt", b_cnt, 32'h0);
        chk("wrap_n_cnt", n_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
